mem_responder: RTL and testbench

Memory-side responder for the core's load/store and fetch port: accepts one request at a time from the pipeline, waits a programmable number of cycles, then returns a response. The block holds a word-organised RAM with byte-strobed writes, flags misaligned and out-of-range accesses, and holds each response until the core accepts it. It sits under `cpu_top`, facing the IF and MEM stages across a valid/ready request channel and a valid/ready response channel.

---
 rtl/mem_responder.sv | 65 ++++++
 tb/tb_mem_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with programmable latency,
// byte-strobed word RAM, and misalignment/range error reporting.
module mem_responder #(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [31:0] addr, wdata;
  logic [3:0] wstrb;
  logic we, bad, commit;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
  assign idx = addr[AW+1:2];
  assign bad = addr[1:0] != 2'b0 || (addr >> (AW + 2)) != 32'd0;
  assign commit = state == WAIT && cnt == 4'(LATENCY);
  assign req_ready = reset && state == IDLE;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      addr <= 32'd0;
      wdata <= 32'd0;
      wstrb <= 4'd0;
      we <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        state <= WAIT;
        cnt <= 4'd0;
        addr <= req_addr;
        wdata <= req_wdata;
        wstrb <= req_wstrb;
        we <= req_we;
      end
    end else if (state == WAIT) begin
      if (commit) begin
        state <= RESP;
        rsp_err <= bad;
        rsp_rdata <= (!we && !bad) ? mem[idx] : 32'd0;
      end else cnt <= cnt + 4'd1;
    end else if (rsp_ready) state <= IDLE;
  // RAM is deliberately outside the reset domain; an aborted WAIT never reaches commit
  always_ff @(posedge clk)
    if (commit && we && !bad)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder at LATENCY 2 and LATENCY 0.
module tb_mem_responder;
  logic clk = 0, reset = 0, req_valid = 0, req_we = 0, rsp_ready = 1, sel = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_wstrb = 0;
  logic s_req_ready, s_rsp_valid, s_rsp_err, f_req_ready, f_rsp_valid, f_rsp_err;
  logic [31:0] s_rsp_rdata, f_rsp_rdata;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int tests = 0, fails = 0, cyc = 0;
  assign req_ready = sel ? f_req_ready : s_req_ready;
  assign rsp_valid = sel ? f_rsp_valid : s_rsp_valid;
  assign rsp_err = sel ? f_rsp_err : s_rsp_err;
  assign rsp_rdata = sel ? f_rsp_rdata : s_rsp_rdata;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_ready(s_req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err)
  );
  mem_responder #(.DEPTH(1024), .LATENCY(0)) u_fast (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_ready(f_req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(f_rsp_rdata), .rsp_err(f_rsp_err)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(logic [31:0] a, logic w, logic [31:0] d, logic [3:0] s);
    int n = 0;
    req_addr = a;
    req_we = w;
    req_wdata = d;
    req_wstrb = s;
    req_valid = 1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    req_wdata = 32'hFFFF_FFFF;
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic xact(logic [31:0] a, logic w, logic [31:0] d, logic [3:0] s,
                      output logic [31:0] rd, output logic e);
    int n;
    send(a, w, d, s);
    wait_rsp(n);
    check("latency", 32'(n), sel ? 32'd1 : 32'd3);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    e = rsp_err;
    @(negedge clk);
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("ready_back", 32'(req_ready), 32'd1);
  endtask
  initial begin
    logic [31:0] rd;
    logic e, seen;
    int acc[$];
    #200000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    logic e, seen;
    int acc[$];
    int n;
    req_valid = 1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    req_valid = 0;
    reset = 1;
    #1 check("rel_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    xact(32'h10, 1, 32'hDEADBEEF, 4'hF, rd, e);
    check("wr_rdata", rd, 32'd0);
    check("wr_err", 32'(e), 32'd0);
    xact(32'h10, 0, 0, 0, rd, e);
    check("rd_word", rd, 32'hDEADBEEF);
    xact(32'h10, 1, 32'h11223344, 4'b0101, rd, e);
    xact(32'h10, 0, 0, 0, rd, e);
    check("strobe", rd, 32'hDE22BE44);
    xact(32'h13, 0, 0, 0, rd, e);
    check("misalign_err", 32'(e), 32'd1);
    check("misalign_rdata", rd, 32'd0);
    xact(32'h0, 1, 32'hA5A5A5A5, 4'hF, rd, e);
    xact(32'h1000, 1, 32'h0BAD0BAD, 4'hF, rd, e);
    check("range_err", 32'(e), 32'd1);
    check("range_rdata", rd, 32'd0);
    xact(32'h0, 0, 0, 0, rd, e);
    check("word0_kept", rd, 32'hA5A5A5A5);
    check("word0_err", 32'(e), 32'd0);
    xact(32'h10, 1, 32'h0, 4'h0, rd, e);
    xact(32'h10, 0, 0, 0, rd, e);
    check("zero_strobe", rd, 32'hDE22BE44);
    rsp_ready = 0;
    send(32'h10, 0, 0, 0);
    wait_rsp(n);
    check("bp_latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      req_valid = i == 1;
      req_we = 1;
      req_addr = 32'h10;
      req_wdata = 32'h0;
      req_wstrb = 4'hF;
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDE22BE44);
      check("bp_err", 32'(rsp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1;
    @(negedge clk);
    check("bp_release", 32'(req_ready), 32'd1);
    check("bp_rsp_drop", 32'(rsp_valid), 32'd0);
    xact(32'h10, 0, 0, 0, rd, e);
    check("bp_no_accept", rd, 32'hDE22BE44);
    for (int f = 0; f < 2; f++) begin
      sel = f == 1;
      xact(32'h20, 1, 32'h12345678, 4'hF, rd, e);
      send(32'h20, 1, 32'hCAFEF00D, 4'hF);
      reset = 0;
      #1 check("abort_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      reset = 1;
      seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (rsp_valid) seen = 1;
      end
      check("abort_no_rsp", 32'(seen), 32'd0);
      xact(32'h20, 0, 0, 0, rd, e);
      check("abort_kept", rd, 32'h12345678);
    end
    req_addr = 32'h4;
    req_we = 1;
    req_wdata = 32'h77;
    req_wstrb = 4'hF;
    req_valid = 1;
    repeat (12) begin
      if (req_ready) acc.push_back(cyc);
      @(negedge clk);
    end
    req_valid = 0;
    check("b2b_count", 32'(acc.size() >= 4), 32'd1);
    for (int i = 1; i < 4 && i < acc.size(); i++) check("b2b_period", 32'(acc[i] - acc[i-1]), 32'd3);
    repeat (4) @(negedge clk);
    xact(32'h4, 0, 0, 0, rd, e);
    check("b2b_data", rd, 32'h77);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
